// File: rtl/alu_exec_control.sv
// ID-stage main decoder, EX-aligned immediate/load-store flags, ALU-control
// decoder and the integer ALU of the 5-stage pipeline.
module alu_exec_control #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [5:0]        opcode,
    output logic [8:0]        op_out,
    output logic              jmp,
    output logic              bne,
    output logic              immediate,
    output logic              andi,
    output logic              ori,
    output logic              addi,
    output logic              ls,
    input  logic [5:0]        ex_funct,
    input  logic [1:0]        ex_alu_op,
    input  logic [DATA_W-1:0] data_a,
    input  logic [DATA_W-1:0] data_b,
    input  logic              alu_stall,
    output logic [2:0]        alu_ctrl,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_NOR = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Control word layout: {MemtoReg,RegWrite, Branch,MemRead,MemWrite, RegDst,ALUSrc,ALUOp[1:0]}
    always_comb begin
        op_out    = 9'b0;
        jmp       = 1'b0;
        bne       = 1'b0;
        immediate = 1'b0;
        andi      = 1'b0;
        ori       = 1'b0;
        addi      = 1'b0;
        ls        = 1'b0;
        case (opcode)
            OP_RTYPE: op_out = 9'b01_000_1010;
            OP_LW: begin
                op_out = 9'b11_010_0100;
                ls     = 1'b1;
            end
            OP_SW: begin
                op_out = 9'b00_001_0100;
                ls     = 1'b1;
            end
            OP_BEQ: op_out = 9'b00_100_0001;
            OP_BNE: begin
                op_out = 9'b00_100_0001;
                bne    = 1'b1;
            end
            OP_J: jmp = 1'b1;
            OP_ADDI: begin
                op_out    = 9'b01_000_0100;
                immediate = 1'b1;
                addi      = 1'b1;
            end
            OP_ANDI: begin
                op_out    = 9'b01_000_0111;
                immediate = 1'b1;
                andi      = 1'b1;
            end
            OP_ORI: begin
                op_out    = 9'b01_000_0111;
                immediate = 1'b1;
                ori       = 1'b1;
            end
            default: ;
        endcase
    end

    // Flags follow the instruction into EX; a bubble zeroes ALUOp externally,
    // so loading them unconditionally during stalls is harmless.
    logic p_andi_d, p_ori_d, p_addi_d, p_ls_d;
    logic p_andi_q, p_ori_q, p_addi_q, p_ls_q;

    always_comb begin
        p_andi_d = andi;
        p_ori_d  = ori;
        p_addi_d = addi;
        p_ls_d   = ls;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            p_andi_q <= 1'b0;
            p_ori_q  <= 1'b0;
            p_addi_q <= 1'b0;
            p_ls_q   <= 1'b0;
        end else begin
            p_andi_q <= p_andi_d;
            p_ori_q  <= p_ori_d;
            p_addi_q <= p_addi_d;
            p_ls_q   <= p_ls_d;
        end
    end

    always_comb begin
        alu_ctrl = ALU_ADD;
        if (p_ls_q) begin
            alu_ctrl = ALU_ADD;
        end else begin
            case (ex_alu_op)
                2'b00: alu_ctrl = ALU_ADD;
                2'b01: alu_ctrl = ALU_SUB;
                2'b10: begin
                    case (ex_funct)
                        FN_ADD:  alu_ctrl = ALU_ADD;
                        FN_SUB:  alu_ctrl = ALU_SUB;
                        FN_AND:  alu_ctrl = ALU_AND;
                        FN_OR:   alu_ctrl = ALU_OR;
                        FN_XOR:  alu_ctrl = ALU_XOR;
                        FN_NOR:  alu_ctrl = ALU_NOR;
                        FN_SLT:  alu_ctrl = ALU_SLT;
                        default: alu_ctrl = ALU_ADD;
                    endcase
                end
                default: begin
                    if (p_andi_q)      alu_ctrl = ALU_AND;
                    else if (p_ori_q)  alu_ctrl = ALU_OR;
                    else               alu_ctrl = ALU_ADD;
                end
            endcase
        end
    end

    logic slt_bit;
    assign slt_bit = ($signed(data_a) < $signed(data_b));

    always_comb begin
        result = '0;
        if (!alu_stall) begin
            case (alu_ctrl)
                ALU_AND: result = data_a & data_b;
                ALU_OR:  result = data_a | data_b;
                ALU_ADD: result = data_a + data_b;
                ALU_NOR: result = ~(data_a | data_b);
                ALU_XOR: result = data_a ^ data_b;
                ALU_SUB: result = data_a - data_b;
                ALU_SLT: result = {{(DATA_W-1){1'b0}}, slt_bit};
                default: result = '0;
            endcase
        end
    end

    assign zero = (result == '0);

endmodule

// File: tb/tb_alu_exec_control.sv
// Directed bench for alu_exec_control: a per-cycle reference model check plus
// hand-computed literal expectations from the test plan.
module tb_alu_exec_control;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  opcode;
    logic [8:0]  op_out;
    logic        jmp, bne, immediate, andi, ori, addi, ls;
    logic [5:0]  ex_funct;
    logic [1:0]  ex_alu_op;
    logic [31:0] data_a, data_b;
    logic        alu_stall;
    logic [2:0]  alu_ctrl;
    logic [31:0] result;
    logic        zero;

    int n_chk  = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    alu_exec_control #(.DATA_W(32)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .op_out(op_out),
        .jmp(jmp), .bne(bne), .immediate(immediate), .andi(andi), .ori(ori),
        .addi(addi), .ls(ls), .ex_funct(ex_funct), .ex_alu_op(ex_alu_op),
        .data_a(data_a), .data_b(data_b), .alu_stall(alu_stall),
        .alu_ctrl(alu_ctrl), .result(result), .zero(zero)
    );

    // Instruction table: opcode, control word, {jmp,bne,imm,andi,ori,addi,ls}
    typedef struct {
        logic [5:0] op;
        logic [8:0] word;
        logic [6:0] flags;
    } dec_t;

    dec_t dtab[9] = '{
        '{6'b000000, 9'b010001010, 7'b0000000},
        '{6'b100011, 9'b110100100, 7'b0000001},
        '{6'b101011, 9'b000010100, 7'b0000001},
        '{6'b000100, 9'b001000001, 7'b0000000},
        '{6'b000101, 9'b001000001, 7'b0100000},
        '{6'b000010, 9'b000000000, 7'b1000000},
        '{6'b001000, 9'b010000100, 7'b0010010},
        '{6'b001100, 9'b010000111, 7'b0011000},
        '{6'b001101, 9'b010000111, 7'b0010100}
    };

    // Opcode of the instruction now in EX; -1 means nothing (reset bubble).
    int m_prev = -1;
    always @(posedge clk) m_prev <= reset ? -1 : int'(opcode);

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic void m_decode(input logic [5:0] op, output logic [8:0] w, output logic [6:0] f);
        w = 9'b0;
        f = 7'b0;
        foreach (dtab[i]) if (dtab[i].op == op) begin
            w = dtab[i].word;
            f = dtab[i].flags;
        end
    endfunction

    function automatic logic [2:0] m_ctrl(input int prev, input logic [1:0] aop, input logic [5:0] fn);
        if (prev == 'h23 || prev == 'h2b) return 3'b010;   // load/store address add
        if (aop == 2'b00) return 3'b010;
        if (aop == 2'b01) return 3'b110;
        if (aop == 2'b11) begin
            if (prev == 'h0c) return 3'b000;
            if (prev == 'h0d) return 3'b001;
            return 3'b010;
        end
        case (fn)
            6'h22:   return 3'b110;
            6'h24:   return 3'b000;
            6'h25:   return 3'b001;
            6'h26:   return 3'b100;
            6'h27:   return 3'b011;
            6'h2a:   return 3'b111;
            default: return 3'b010;
        endcase
    endfunction

    function automatic logic [31:0] m_alu(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b, input logic st);
        longint sa, sb;
        if (st) return 32'h0;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (c)
            3'b000:  return a & b;
            3'b001:  return a | b;
            3'b010:  return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
            3'b011:  return ~(a | b);
            3'b100:  return a ^ b;
            3'b110:  return 32'((64'(a) + 64'h1_0000_0000 - 64'(b)) % 64'h1_0000_0000);
            3'b111:  return (sa < sb) ? 32'd1 : 32'd0;
            default: return 32'h0;
        endcase
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            logic [8:0]  w;
            logic [6:0]  f;
            logic [2:0]  c;
            logic [31:0] r;
            m_decode(opcode, w, f);
            c = m_ctrl(m_prev, ex_alu_op, ex_funct);
            r = m_alu(c, data_a, data_b, alu_stall);
            check("m_op_out", 32'(op_out), 32'(w));
            check("m_flags", 32'({jmp, bne, immediate, andi, ori, addi, ls}), 32'(f));
            check("m_alu_ctrl", 32'(alu_ctrl), 32'(c));
            check("m_result", result, r);
            check("m_zero", 32'(zero), 32'(r == 32'h0));
        end
    end

    task automatic step(input logic rst, input logic [5:0] op, input logic [1:0] aop,
                        input logic [5:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input logic st);
        @(posedge clk);
        #1;
        reset = rst; opcode = op; ex_alu_op = aop; ex_funct = fn;
        data_a = a; data_b = b; alu_stall = st;
        #1;
    endtask

    initial begin
        reset = 1'b1; opcode = 6'b001100; ex_alu_op = 2'b11; ex_funct = 6'h0;
        data_a = 32'hF0F0; data_b = 32'h00FF; alu_stall = 1'b0;
        @(posedge clk);
        #1;
        chk_en = 1'b1;
        // In reset the andi flag cannot load, so ALUOp=11 falls back to ADD
        step(1, 6'b001100, 2'b11, 6'h0, 32'hF0F0, 32'h00FF, 0);
        check("rst_ctrl", 32'(alu_ctrl), 32'h2);
        check("rst_result", result, 32'hF1EF);

        step(0, 6'b100011, 2'b00, 6'h0, 32'h1, 32'h2, 0);
        check("dec_lw", 32'(op_out), 32'h1A4);
        check("dec_lw_ls", 32'(ls), 32'h1);
        step(0, 6'b000101, 2'b00, 6'h0, 32'h1, 32'h2, 0);
        check("dec_bne", 32'(op_out), 32'h041);
        check("dec_bne_flag", 32'(bne), 32'h1);
        step(0, 6'b111111, 2'b00, 6'h0, 32'h1, 32'h2, 0);
        check("dec_bad", 32'({op_out, jmp, bne, immediate, andi, ori, addi, ls}), 32'h0);

        step(0, 6'b000000, 2'b10, 6'b100010, 32'd5, 32'd7, 0);
        check("r_sub_ctrl", 32'(alu_ctrl), 32'h6);
        check("r_sub_res", result, 32'hFFFFFFFE);
        check("r_sub_zero", 32'(zero), 32'h0);
        step(0, 6'b000000, 2'b10, 6'b101010, 32'd5, 32'd7, 0);
        check("r_slt", result, 32'h1);
        step(0, 6'b000000, 2'b10, 6'b101010, 32'hFFFFFFFF, 32'd1, 0);
        check("r_slt_signed", result, 32'h1);

        step(0, 6'b001100, 2'b11, 6'h0, 32'hF0F0, 32'h00FF, 0);
        check("andi_early", 32'(alu_ctrl), 32'h2);
        step(0, 6'b000000, 2'b11, 6'h0, 32'hF0F0, 32'h00FF, 0);
        check("andi_ctrl", 32'(alu_ctrl), 32'h0);
        check("andi_res", result, 32'h00F0);

        step(0, 6'b101011, 2'b00, 6'h0, 32'h0, 32'h0, 0);
        step(0, 6'b000000, 2'b10, 6'b100100, 32'h100, 32'h4, 0);
        check("ls_prio_ctrl", 32'(alu_ctrl), 32'h2);
        check("ls_prio_res", result, 32'h104);

        step(1, 6'b001101, 2'b00, 6'h0, 32'h0, 32'h0, 0);
        step(0, 6'b001101, 2'b11, 6'h0, 32'hF0, 32'h1F, 0);
        check("ori_rst_res", result, 32'h10F);
        step(0, 6'b000000, 2'b11, 6'h0, 32'hF0, 32'h1F, 0);
        check("ori_reload", 32'(alu_ctrl), 32'h1);
        check("ori_res", result, 32'hFF);

        step(0, 6'b000000, 2'b00, 6'h0, 32'hFFFFFFFF, 32'h1, 0);
        check("wrap_res", result, 32'h0);
        check("wrap_zero", 32'(zero), 32'h1);
        step(0, 6'b000000, 2'b10, 6'b100101, 32'h3, 32'h4, 1);
        check("stall_res", result, 32'h0);
        check("stall_zero", 32'(zero), 32'h1);
        check("stall_ctrl", 32'(alu_ctrl), 32'h1);

        // Sweep every instruction through EX with each ALUOp and varied funct
        for (int i = 0; i < 9; i++) begin
            for (int k = 0; k < 4; k++) begin
                step(0, dtab[i].op, 2'(k), 6'h20 + 6'(((i * 4) + k) % 11),
                     $urandom, $urandom, ($urandom_range(0, 7) == 0));
            end
        end

        @(negedge clk);
        #1;
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
